// File: rtl/vset_pkg.sv
// Shared types for the vset configuration unit: vtype layout, vsew/vlmul encodings,
// the vill-only reset vtype and the unit FSM states.
package vset_pkg;

  localparam int XLEN = 64;

  typedef enum logic [2:0] {
    VSEW_8     = 3'd0,
    VSEW_16    = 3'd1,
    VSEW_32    = 3'd2,
    VSEW_64    = 3'd3,
    VSEW_RSVD4 = 3'd4,
    VSEW_RSVD5 = 3'd5,
    VSEW_RSVD6 = 3'd6,
    VSEW_RSVD7 = 3'd7
  } vsew_e;

  typedef enum logic [2:0] {
    LMUL_1    = 3'd0,
    LMUL_2    = 3'd1,
    LMUL_4    = 3'd2,
    LMUL_8    = 3'd3,
    LMUL_RSVD = 3'd4,
    LMUL_F8   = 3'd5,
    LMUL_F4   = 3'd6,
    LMUL_F2   = 3'd7
  } vlmul_e;

  typedef struct packed {
    logic             vill;
    logic [XLEN-10:0] reserved;
    logic             vma;
    logic             vta;
    vsew_e            vsew;
    vlmul_e           vlmul;
  } vtype_t;

  localparam logic [XLEN-1:0] VILL_RESET = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_RESP,
    S_WAIT_CMT
  } state_e;

endpackage

// File: rtl/vset_cfg_unit_if.sv
// Request/response bundle between issue logic and the vset configuration unit.
// Signal suffixes are from the unit's point of view.
interface vset_cfg_unit_if #(
  parameter int TRANS_ID_BITS = 3
);
  import vset_pkg::*;

  logic                     req_valid_i;
  logic                     req_ready_o;
  logic [XLEN-1:0]          req_avl_i;
  logic [XLEN-1:0]          req_vtype_i;
  logic                     req_rs1_x0_i;
  logic                     req_rd_x0_i;
  logic [TRANS_ID_BITS-1:0] req_trans_id_i;

  logic                     res_valid_o;
  logic                     res_ready_i;
  logic [XLEN-1:0]          res_data_o;
  logic [TRANS_ID_BITS-1:0] res_trans_id_o;
  logic                     res_ex_valid_o;

  modport master (
    output req_valid_i, req_avl_i, req_vtype_i, req_rs1_x0_i, req_rd_x0_i, req_trans_id_i,
    output res_ready_i,
    input  req_ready_o, res_valid_o, res_data_o, res_trans_id_o, res_ex_valid_o
  );

  modport slave (
    input  req_valid_i, req_avl_i, req_vtype_i, req_rs1_x0_i, req_rd_x0_i, req_trans_id_i,
    input  res_ready_i,
    output req_ready_o, res_valid_o, res_data_o, res_trans_id_o, res_ex_valid_o
  );

endinterface

// File: rtl/vset_vlmax_calc.sv
// Combinational VLMAX and vtype legality from a requested vtype.
// Shift-only: VLMAX = (VLEN/SEW) scaled by LMUL.
module vset_vlmax_calc
  import vset_pkg::*;
#(
  parameter int VLEN = 64,
  parameter int ELEN = 64
) (
  input  vtype_t          vtype_i,
  output logic [XLEN-1:0] vlmax_o,
  output logic            illegal_o
);

  logic [2:0]      vsew;
  logic [2:0]      vlmul;
  logic            frac;
  logic [XLEN-1:0] sew;
  logic [XLEN-1:0] per_reg;
  logic [XLEN-1:0] frac_sew;
  logic            unused_fields;

  assign vsew          = vtype_i.vsew;
  assign vlmul         = vtype_i.vlmul;
  assign frac          = vlmul[2];
  assign unused_fields = ^{vtype_i.vill, vtype_i.vma, vtype_i.vta};

  always_comb begin
    sew      = XLEN'(8) << vsew;
    per_reg  = XLEN'(VLEN) >> ({1'b0, vsew} + 4'd3);
    // SEW scaled up by the fractional divisor must still fit within ELEN
    frac_sew = sew << (4'd8 - {1'b0, vlmul});
    if (!frac) begin
      vlmax_o = per_reg << vlmul[1:0];
    end else begin
      vlmax_o = per_reg >> (4'd8 - {1'b0, vlmul});
    end
    illegal_o = (|vtype_i.reserved)
             || vsew[2]
             || (sew > XLEN'(ELEN))
             || (vlmul == 3'd4)
             || (frac && (frac_sew > XLEN'(ELEN)))
             || (vlmax_o == '0);
  end

endmodule

// File: rtl/vset_cfg_unit.sv
// vsetvli/vsetivli/vsetvl execution unit: one outstanding instruction, result written
// back speculatively, architectural vl/vtype updated on commit.
// Optional: define VSET_CFG_ILLEGAL_TRAP_EN to trap illegal vtype instead of setting vill.
module vset_cfg_unit
  import vset_pkg::*;
#(
  parameter int VLEN          = 64,
  parameter int ELEN          = 64,
  parameter int TRANS_ID_BITS = 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  vset_cfg_unit_if.slave  bus,
  input  logic            commit_i,
  output logic [XLEN-1:0] vl_o,
  output logic [XLEN-1:0] vtype_o
);

  state_e                   state_q, state_d;
  logic [XLEN-1:0]          avl_q, avl_d;
  logic [XLEN-1:0]          vtype_req_q, vtype_req_d;
  logic                     rs1_x0_q, rs1_x0_d;
  logic                     rd_x0_q, rd_x0_d;
  logic [TRANS_ID_BITS-1:0] tid_q, tid_d;
  logic                     res_valid_q, res_valid_d;
  logic [XLEN-1:0]          res_data_q, res_data_d;
  logic [TRANS_ID_BITS-1:0] res_tid_q, res_tid_d;
  logic [XLEN-1:0]          pend_vl_q, pend_vl_d;
  logic [XLEN-1:0]          pend_vtype_q, pend_vtype_d;
  logic [XLEN-1:0]          vl_q, vl_d;
  logic [XLEN-1:0]          vtype_q, vtype_d;
`ifdef VSET_CFG_ILLEGAL_TRAP_EN
  logic                     res_ex_q, res_ex_d;
`endif

  logic [XLEN-1:0] vlmax;
  logic            vtype_illegal;
  logic [XLEN-1:0] sel_vl;
  logic            calc_illegal;
  logic [XLEN-1:0] calc_vl;
  logic [XLEN-1:0] calc_vtype;

  vset_vlmax_calc #(
    .VLEN (VLEN),
    .ELEN (ELEN)
  ) u_vlmax_calc (
    .vtype_i   (vtype_t'(vtype_req_q)),
    .vlmax_o   (vlmax),
    .illegal_o (vtype_illegal)
  );

  // Keeping vl with rs1=rd=x0 reads the architectural vl, which is current since
  // only one vset can be in flight.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    calc_illegal = vtype_illegal;
    sel_vl       = vlmax;
    if (!rs1_x0_q) begin
      sel_vl = (avl_q < vlmax) ? avl_q : vlmax;
    end else if (rd_x0_q) begin
      sel_vl = vl_q;
      if (vl_q > vlmax) calc_illegal = 1'b1;
    end
    calc_vl    = calc_illegal ? '0 : sel_vl;
    calc_vtype = calc_illegal ? VILL_RESET : {1'b0, vtype_req_q[XLEN-2:0]};
  end

  always_comb begin
    state_d      = state_q;
    avl_d        = avl_q;
    vtype_req_d  = vtype_req_q;
    rs1_x0_d     = rs1_x0_q;
    rd_x0_d      = rd_x0_q;
    tid_d        = tid_q;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_tid_d    = res_tid_q;
    pend_vl_d    = pend_vl_q;
    pend_vtype_d = pend_vtype_q;
    vl_d         = vl_q;
    vtype_d      = vtype_q;
`ifdef VSET_CFG_ILLEGAL_TRAP_EN
    res_ex_d     = res_ex_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid_i) begin
          avl_d       = bus.req_avl_i;
          vtype_req_d = bus.req_vtype_i;
          rs1_x0_d    = bus.req_rs1_x0_i;
          rd_x0_d     = bus.req_rd_x0_i;
          tid_d       = bus.req_trans_id_i;
          state_d     = S_CALC;
        end
      end
      S_CALC: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          res_valid_d  = 1'b1;
          res_data_d   = calc_vl;
          res_tid_d    = tid_q;
          pend_vl_d    = calc_vl;
          pend_vtype_d = calc_vtype;
`ifdef VSET_CFG_ILLEGAL_TRAP_EN
          res_ex_d     = calc_illegal;
`endif
          state_d      = S_RESP;
        end
      end
      S_RESP: begin
        if (flush_i) begin
          res_valid_d = 1'b0;
`ifdef VSET_CFG_ILLEGAL_TRAP_EN
          res_ex_d    = 1'b0;
`endif
          state_d     = S_IDLE;
        end else if (bus.res_ready_i) begin
          res_valid_d = 1'b0;
`ifdef VSET_CFG_ILLEGAL_TRAP_EN
          res_ex_d    = 1'b0;
          state_d     = res_ex_q ? S_IDLE : S_WAIT_CMT;
`else
          state_d     = S_WAIT_CMT;
`endif
        end
      end
      S_WAIT_CMT: begin
        // Commit wins over a simultaneous flush: the instruction is already retiring.
        if (commit_i) begin
          vl_d    = pend_vl_q;
          vtype_d = pend_vtype_q;
          state_d = S_IDLE;
        end else if (flush_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      state_q      <= S_IDLE;
      avl_q        <= '0;
      vtype_req_q  <= '0;
      rs1_x0_q     <= 1'b0;
      rd_x0_q      <= 1'b0;
      tid_q        <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_tid_q    <= '0;
      pend_vl_q    <= '0;
      pend_vtype_q <= VILL_RESET;
      vl_q         <= '0;
      vtype_q      <= VILL_RESET;
`ifdef VSET_CFG_ILLEGAL_TRAP_EN
      res_ex_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      avl_q        <= avl_d;
      vtype_req_q  <= vtype_req_d;
      rs1_x0_q     <= rs1_x0_d;
      rd_x0_q      <= rd_x0_d;
      tid_q        <= tid_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_tid_q    <= res_tid_d;
      pend_vl_q    <= pend_vl_d;
      pend_vtype_q <= pend_vtype_d;
      vl_q         <= vl_d;
      vtype_q      <= vtype_d;
`ifdef VSET_CFG_ILLEGAL_TRAP_EN
      res_ex_q     <= res_ex_d;
`endif
    end
  end

  assign bus.req_ready_o    = (state_q == S_IDLE) && !rst_i;
  assign bus.res_valid_o    = res_valid_q;
  assign bus.res_data_o     = res_data_q;
  assign bus.res_trans_id_o = res_tid_q;
`ifdef VSET_CFG_ILLEGAL_TRAP_EN
  assign bus.res_ex_valid_o = res_ex_q;
`else
  assign bus.res_ex_valid_o = 1'b0;
`endif
  assign vl_o               = vl_q;
  assign vtype_o            = vtype_q;

endmodule

// File: tb/tb_vset_cfg_unit.sv
// Self-checking bench for vset_cfg_unit: directed scenarios plus randomized vsets
// checked against an arithmetic reference model of vl/vtype selection.
module tb_vset_cfg_unit;
  import vset_pkg::*;

  localparam int VLEN = 64;
  localparam int ELEN = 64;
`ifdef VSET_CFG_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        commit;
  logic [63:0] vl;
  logic [63:0] vtype;

  int          pass_cnt = 0;
  int          chk_cnt  = 0;
  logic [63:0] arch_vl;
  logic [63:0] arch_vtype;

  vset_cfg_unit_if #(.TRANS_ID_BITS(3)) bus ();

  vset_cfg_unit #(
    .VLEN          (VLEN),
    .ELEN          (ELEN),
    .TRANS_ID_BITS (3)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .flush_i  (flush),
    .bus      (bus),
    .commit_i (commit),
    .vl_o     (vl),
    .vtype_o  (vtype)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference: SEW = 8*2^vsew, LMUL = 2^vlmul or 1/2^(8-vlmul), VLMAX = VLEN*LMUL/SEW.
  function automatic void ref_vset(input logic [63:0] avl, input logic [63:0] vt,
                                   input bit rs1x0, input bit rdx0, input logic [63:0] cur_vl,
                                   output logic [63:0] nvl, output logic [63:0] nvt,
                                   output bit ill);
    longint unsigned sew, den, vlmax;
    int vsew, vlmul;
    vsew  = int'(vt[5:3]);
    vlmul = int'(vt[2:0]);
    sew   = 64'(8 * (2 ** vsew));
    vlmax = 0;
    ill   = (vt[62:8] != '0) || (vsew >= 4) || (vlmul == 4);
    if (!ill) begin
      if (vlmul < 4) begin
        vlmax = (64'(VLEN) / sew) * 64'(2 ** vlmul);
      end else begin
        den = 64'(2 ** (8 - vlmul));
        if (sew * den > 64'(ELEN)) ill = 1'b1;
        vlmax = 64'(VLEN) / (sew * den);
      end
      if (vlmax == 0) ill = 1'b1;
    end
    nvl = '0;
    if (!ill) begin
      if (!rs1x0)     nvl = (avl < vlmax) ? avl : vlmax;
      else if (!rdx0) nvl = vlmax;
      else begin
        nvl = cur_vl;
        if (cur_vl > vlmax) ill = 1'b1;
      end
    end
    if (ill) begin
      nvl = '0;
      nvt = VILL_RESET;
    end else begin
      nvt = {1'b0, vt[62:0]};
    end
  endfunction

  // Waits (bounded) for ready, then presents one request for a single cycle.
  task automatic issue(input logic [63:0] avl, input logic [63:0] vt, input bit rs1x0,
                       input bit rdx0, input logic [2:0] tid, input string tag);
    int waited;
    waited = 0;
    while (bus.req_ready_o !== 1'b1 && waited < 10) begin
      @(posedge clk); #1;
      waited++;
    end
    chk_cnt++;
    if (bus.req_ready_o !== 1'b1) $display("FAIL %s req_ready got %b want 1", tag, bus.req_ready_o);
    else pass_cnt++;
    bus.req_valid_i    = 1'b1;
    bus.req_avl_i      = avl;
    bus.req_vtype_i    = vt;
    bus.req_rs1_x0_i   = rs1x0;
    bus.req_rd_x0_i    = rdx0;
    bus.req_trans_id_i = tid;
    @(posedge clk); #1;
    bus.req_valid_i    = 1'b0;
  endtask

  // Full transaction: latency, response content, back-pressure stability, commit.
  task automatic run_vset(input logic [63:0] avl, input logic [63:0] vt, input bit rs1x0,
                          input bit rdx0, input int hold, input string tag);
    logic [63:0] evl, evt;
    logic [2:0]  tid;
    bit          ill, ex;
    ref_vset(avl, vt, rs1x0, rdx0, arch_vl, evl, evt, ill);
    ex  = TRAP && ill;
    tid = 3'($urandom);
    issue(avl, vt, rs1x0, rdx0, tid, tag);
    chk_cnt++;
    if (bus.res_valid_o !== 1'b0) $display("FAIL %s early res_valid got %b want 0", tag, bus.res_valid_o);
    else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++;
    if ({bus.res_valid_o, bus.res_data_o, bus.res_trans_id_o, bus.res_ex_valid_o} !== {1'b1, evl, tid, ex})
      $display("FAIL %s response got v=%b data=%h id=%0d ex=%b want v=1 data=%h id=%0d ex=%b", tag,
               bus.res_valid_o, bus.res_data_o, bus.res_trans_id_o, bus.res_ex_valid_o, evl, tid, ex);
    else pass_cnt++;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk_cnt++;
      if ({bus.res_valid_o, bus.res_data_o, bus.res_trans_id_o} !== {1'b1, evl, tid})
        $display("FAIL %s stall%0d got v=%b data=%h id=%0d want v=1 data=%h id=%0d", tag, i,
                 bus.res_valid_o, bus.res_data_o, bus.res_trans_id_o, evl, tid);
      else pass_cnt++;
    end
    bus.res_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.res_ready_i = 1'b0;
    chk_cnt++;
    if (bus.res_valid_o !== 1'b0) $display("FAIL %s res_valid after handshake got %b want 0", tag, bus.res_valid_o);
    else pass_cnt++;
    commit = 1'b1;
    @(posedge clk); #1;
    commit = 1'b0;
    if (!ex) begin
      arch_vl    = evl;
      arch_vtype = evt;
    end
    chk_cnt++;
    if (vl !== arch_vl || vtype !== arch_vtype)
      $display("FAIL %s commit got vl=%h vtype=%h want vl=%h vtype=%h", tag, vl, vtype, arch_vl, arch_vtype);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst                = 1'b1;
    flush              = 1'b0;
    commit             = 1'b0;
    bus.req_valid_i    = 1'b0;
    bus.req_avl_i      = '0;
    bus.req_vtype_i    = '0;
    bus.req_rs1_x0_i   = 1'b0;
    bus.req_rd_x0_i    = 1'b0;
    bus.req_trans_id_i = '0;
    bus.res_ready_i    = 1'b0;
    arch_vl            = '0;
    arch_vtype         = VILL_RESET;
    repeat (2) @(posedge clk);
    #1;
    chk_cnt++;
    if (bus.req_ready_o !== 1'b0) $display("FAIL reset ready got %b want 0", bus.req_ready_o);
    else pass_cnt++;
    chk_cnt++;
    if ({bus.res_valid_o, bus.res_data_o, bus.res_trans_id_o, bus.res_ex_valid_o} !== {1'b0, 64'd0, 3'd0, 1'b0})
      $display("FAIL reset res got v=%b data=%h id=%0d ex=%b want all 0", bus.res_valid_o,
               bus.res_data_o, bus.res_trans_id_o, bus.res_ex_valid_o);
    else pass_cnt++;
    chk_cnt++;
    if (vl !== 64'd0 || vtype !== VILL_RESET)
      $display("FAIL reset arch got vl=%h vtype=%h want vl=0 vtype=%h", vl, vtype, VILL_RESET);
    else pass_cnt++;
    rst = 1'b0;
    @(posedge clk); #1;
    chk_cnt++;
    if (bus.req_ready_o !== 1'b1) $display("FAIL post_reset ready got %b want 1", bus.req_ready_o);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    run_vset(64'd5, 64'h00, 1'b0, 1'b0, 0, "basic_avl5");
    run_vset(64'd20, 64'h09, 1'b0, 1'b0, 3, "backpressure_sew16_m2");
  endtask

  task automatic test_x0_forms();
    run_vset(64'd0, 64'h13, 1'b1, 1'b0, 0, "x0_vlmax_sew32_m8");
    run_vset(64'd0, 64'h07, 1'b1, 1'b1, 0, "x0_keep_exceeds");
    run_vset(64'd0, 64'h13, 1'b1, 1'b0, 0, "x0_vlmax_again");
    run_vset(64'd0, 64'h0B, 1'b1, 1'b1, 1, "x0_keep_legal");
  endtask

  task automatic test_illegal();
    run_vset(64'd5, 64'h00, 1'b0, 1'b0, 0, "pre_illegal");
    run_vset(64'd7, 64'h1F, 1'b0, 1'b0, 1, "illegal_sew64_mf2");
    run_vset(64'd5, 64'h00, 1'b0, 1'b0, 0, "pre_rsvd");
    run_vset(64'd3, 64'h100, 1'b0, 1'b0, 0, "illegal_rsvd_bit8");
    run_vset(64'd3, 64'h04, 1'b0, 1'b0, 0, "illegal_lmul_rsvd");
    run_vset(64'd3, 64'h20, 1'b0, 1'b0, 0, "illegal_sew128");
  endtask

  task automatic test_boundary();
    run_vset(64'hFFFF_FFFF_FFFF_FFFF, 64'h03, 1'b0, 1'b0, 0, "avl_max_sew8_m8");
    run_vset(64'h0000_0001_0000_0000, 64'h00, 1'b0, 1'b0, 0, "avl_upper_bits");
    run_vset(64'd8, 64'h00, 1'b0, 1'b0, 0, "avl_eq_vlmax");
    run_vset(64'd9, 64'hC5, 1'b0, 1'b0, 0, "sew8_mf8_vma_vta");
  endtask

  task automatic test_random();
    logic [63:0] avl, vt;
    bit          r1, rd;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) == 0) avl = {$urandom, $urandom};
      else                            avl = 64'($urandom_range(0, 70));
      vt      = '0;
      vt[2:0] = 3'($urandom);
      vt[5:3] = 3'($urandom_range(0, 4));
      vt[6]   = 1'($urandom);
      vt[7]   = 1'($urandom);
      if ($urandom_range(0, 9) == 0) vt[8 + $urandom_range(0, 54)] = 1'b1;
      r1 = ($urandom_range(0, 2) == 0);
      rd = 1'($urandom);
      run_vset(avl, vt, r1, rd, $urandom_range(0, 2), "random");
    end
  endtask

  task automatic test_flush_calc();
    issue(64'd9, 64'h00, 1'b0, 1'b0, 3'd1, "flush_calc");
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk_cnt++;
    if (bus.req_ready_o !== 1'b1 || bus.res_valid_o !== 1'b0)
      $display("FAIL flush_calc got ready=%b res_valid=%b want ready=1 res_valid=0", bus.req_ready_o, bus.res_valid_o);
    else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++;
    if (bus.res_valid_o !== 1'b0 || vl !== arch_vl || vtype !== arch_vtype)
      $display("FAIL flush_calc_arch got v=%b vl=%h vtype=%h want v=0 vl=%h vtype=%h", bus.res_valid_o, vl, vtype, arch_vl, arch_vtype);
    else pass_cnt++;
  endtask

  task automatic test_flush_resp();
    issue(64'd4, 64'h08, 1'b0, 1'b0, 3'd2, "flush_resp");
    @(posedge clk); #1;
    chk_cnt++;
    if (bus.res_valid_o !== 1'b1) $display("FAIL flush_resp_pre res_valid got %b want 1", bus.res_valid_o);
    else pass_cnt++;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk_cnt++;
    if (bus.res_valid_o !== 1'b0 || bus.req_ready_o !== 1'b1 || vl !== arch_vl || vtype !== arch_vtype)
      $display("FAIL flush_resp got v=%b ready=%b vl=%h vtype=%h want v=0 ready=1 vl=%h vtype=%h",
               bus.res_valid_o, bus.req_ready_o, vl, vtype, arch_vl, arch_vtype);
    else pass_cnt++;
  endtask

  task automatic test_flush_wait();
    run_vset(64'd6, 64'h00, 1'b0, 1'b0, 0, "pre_flush_wait");
    issue(64'd3, 64'h00, 1'b0, 1'b0, 3'd3, "flush_wait");
    @(posedge clk); #1;
    bus.res_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.res_ready_i = 1'b0;
    chk_cnt++;
    if (bus.req_ready_o !== 1'b0) $display("FAIL wait_cmt ready got %b want 0", bus.req_ready_o);
    else pass_cnt++;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk_cnt++;
    if (bus.req_ready_o !== 1'b1) $display("FAIL flush_wait ready got %b want 1", bus.req_ready_o);
    else pass_cnt++;
    commit = 1'b1;
    @(posedge clk); #1;
    commit = 1'b0;
    chk_cnt++;
    if (vl !== arch_vl || vtype !== arch_vtype)
      $display("FAIL flush_wait_arch got vl=%h vtype=%h want vl=%h vtype=%h", vl, vtype, arch_vl, arch_vtype);
    else pass_cnt++;
  endtask

  task automatic test_flush_commit();
    logic [63:0] evl, evt;
    bit          ill;
    ref_vset(64'd2, 64'h08, 1'b0, 1'b0, arch_vl, evl, evt, ill);
    issue(64'd2, 64'h08, 1'b0, 1'b0, 3'd4, "flush_commit");
    @(posedge clk); #1;
    bus.res_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.res_ready_i = 1'b0;
    flush  = 1'b1;
    commit = 1'b1;
    @(posedge clk); #1;
    flush  = 1'b0;
    commit = 1'b0;
    arch_vl    = evl;
    arch_vtype = evt;
    chk_cnt++;
    if (vl !== arch_vl || vtype !== arch_vtype || bus.req_ready_o !== 1'b1)
      $display("FAIL flush_commit got vl=%h vtype=%h ready=%b want vl=%h vtype=%h ready=1",
               vl, vtype, bus.req_ready_o, arch_vl, arch_vtype);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    issue(64'd4, 64'h00, 1'b0, 1'b0, 3'd5, "reset_mid");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    arch_vl    = '0;
    arch_vtype = VILL_RESET;
    chk_cnt++;
    if (bus.res_valid_o !== 1'b0 || vl !== 64'd0 || vtype !== VILL_RESET || bus.req_ready_o !== 1'b0)
      $display("FAIL reset_mid got v=%b vl=%h vtype=%h ready=%b want v=0 vl=0 vtype=%h ready=0",
               bus.res_valid_o, vl, vtype, bus.req_ready_o, VILL_RESET);
    else pass_cnt++;
    rst = 1'b0;
    @(posedge clk); #1;
    chk_cnt++;
    if (bus.req_ready_o !== 1'b1) $display("FAIL reset_mid_release ready got %b want 1", bus.req_ready_o);
    else pass_cnt++;
    run_vset(64'd3, 64'h00, 1'b0, 1'b0, 0, "after_reset_mid");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_x0_forms();
    test_illegal();
    test_boundary();
    test_random();
    test_flush_calc();
    test_flush_resp();
    test_flush_wait();
    test_flush_commit();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
